// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: issues fetches at i_pc, selects the next PC
// on each accepted instruction, and traps to TRAP_VEC on a fetch timeout.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0080,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_next_pc,
  input  logic        i_stall,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  output logic        o_inst_valid,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] adv_tgt;
  logic        advance;
  logic        trap_entry;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    if (i_jump)          adv_tgt = i_jump_target;
    else if (i_br_taken) adv_tgt = i_br_target;
    else if (pend_vld_q) adv_tgt = pend_tgt_q;
    else                 adv_tgt = i_pc + 32'd4;
  end

  always_comb begin
    state_d      = state_q;
    pend_vld_d   = pend_vld_q;
    pend_tgt_d   = pend_tgt_q;
    wait_d       = '0;
    advance      = 1'b0;
    trap_entry   = 1'b0;
    o_next_pc    = i_pc;
    o_imem_req   = 1'b0;
    o_imem_addr  = '0;
    o_inst_valid = 1'b0;
    o_fetch_err  = 1'b0;

    if (i_rst) begin
      o_next_pc  = RESET_VEC;
      state_d    = IDLE;
      pend_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          o_next_pc = RESET_VEC;
          state_d   = FETCH;
        end
        FETCH: begin
          o_imem_req  = 1'b1;
          o_imem_addr = i_pc;
          if (i_imem_ack) begin
            advance      = 1'b1;
            o_inst_valid = 1'b1;
            o_next_pc    = adv_tgt;
            state_d      = i_stall ? HOLD : FETCH;
          end else if (wait_q == TIMEOUT_C) begin
            trap_entry = 1'b1;
            state_d    = TRAP;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        HOLD: begin
          if (!i_stall) state_d = FETCH;
        end
        TRAP: begin
          o_fetch_err = 1'b1;
          o_next_pc   = TRAP_VEC;
          state_d     = FETCH;
        end
        default: state_d = IDLE;
      endcase

      // Any advance retires the pending redirect: either it was used, or a
      // same-cycle strobe superseded it.
      if (advance || trap_entry) begin
        pend_vld_d = 1'b0;
      end else if (i_jump) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = i_jump_target;
      end else if (i_br_taken) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = i_br_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written timeout/reset
// sequences, then random stimulus against a behavioural reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0080;
  localparam int          TIMEOUT   = 15;

  typedef struct packed {
    logic        rst, stall, jump, br, ack;
    logic [31:0] pc, jt, bt;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid, err;
    logic [31:0] npc;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t want;
  } vec_t;

  typedef enum {M_IDLE, M_FETCH, M_HOLD, M_TRAP} mode_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_stall = 1'b0, i_jump = 1'b0, i_br_taken = 1'b0, i_imem_ack = 1'b0;
  logic [31:0] i_pc = '0, i_jump_target = '0, i_br_target = '0;
  logic [31:0] o_next_pc, o_imem_addr;
  logic        o_imem_req, o_inst_valid, o_fetch_err;

  int errors = 0;
  int checks = 0;

  mode_t       m_mode = M_IDLE;
  logic [31:0] m_pend[$];
  int          m_waited = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VEC(RESET_VEC),
    .TRAP_VEC (TRAP_VEC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_pc         (i_pc),
    .o_next_pc    (o_next_pc),
    .i_stall      (i_stall),
    .i_jump       (i_jump),
    .i_jump_target(i_jump_target),
    .i_br_taken   (i_br_taken),
    .i_br_target  (i_br_target),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .o_inst_valid (o_inst_valid),
    .o_fetch_err  (o_fetch_err)
  );

  function automatic in_t mk(input logic rst, input logic [31:0] pc, input logic stall,
                             input logic jump, input logic [31:0] jt,
                             input logic br, input logic [31:0] bt, input logic ack);
    in_t x;
    x.rst = rst; x.pc = pc; x.stall = stall; x.jump = jump; x.jt = jt;
    x.br = br; x.bt = bt; x.ack = ack;
    return x;
  endfunction

  function automatic out_t mo(input logic req, input logic [31:0] addr, input logic valid,
                              input logic err, input logic [31:0] npc);
    out_t o;
    o.req = req; o.addr = addr; o.valid = valid; o.err = err; o.npc = npc;
    return o;
  endfunction

  // Reference model: latest redirect strobe wins; at most one is remembered.
  function automatic void m_remember(input in_t x);
    if (x.jump) begin
      m_pend.delete(); m_pend.push_back(x.jt);
    end else if (x.br) begin
      m_pend.delete(); m_pend.push_back(x.bt);
    end
  endfunction

  function automatic void model_step(input in_t x, output out_t e);
    e = '0;
    if (x.rst) begin
      e.npc = RESET_VEC;
      m_mode = M_IDLE; m_pend.delete(); m_waited = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        e.npc = RESET_VEC;
        m_remember(x);
        m_mode = M_FETCH; m_waited = 0;
      end
      M_FETCH: begin
        e.req = 1'b1; e.addr = x.pc;
        if (x.ack) begin
          e.valid = 1'b1;
          if (x.jump)                e.npc = x.jt;
          else if (x.br)             e.npc = x.bt;
          else if (m_pend.size() > 0) e.npc = m_pend[0];
          else                       e.npc = x.pc + 32'd4;
          m_pend.delete(); m_waited = 0;
          m_mode = x.stall ? M_HOLD : M_FETCH;
        end else begin
          e.npc = x.pc;
          if (m_waited == TIMEOUT) begin
            m_pend.delete(); m_mode = M_TRAP; m_waited = 0;
          end else begin
            m_remember(x); m_waited++;
          end
        end
      end
      M_HOLD: begin
        e.npc = x.pc;
        m_remember(x);
        if (!x.stall) begin m_mode = M_FETCH; m_waited = 0; end
      end
      default: begin
        e.err = 1'b1; e.npc = TRAP_VEC;
        m_remember(x);
        m_mode = M_FETCH; m_waited = 0;
      end
    endcase
  endfunction

  task automatic cycle(input in_t x, output out_t got, output out_t mexp);
    i_rst = x.rst; i_pc = x.pc; i_stall = x.stall;
    i_jump = x.jump; i_jump_target = x.jt;
    i_br_taken = x.br; i_br_target = x.bt; i_imem_ack = x.ack;
    #4;
    got.req = o_imem_req; got.addr = o_imem_addr; got.valid = o_inst_valid;
    got.err = o_fetch_err; got.npc = o_next_pc;
    model_step(x, mexp);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b err=%0b next_pc=%h, want req=%0b addr=%h valid=%0b err=%0b next_pc=%h",
               name, got.req, got.addr, got.valid, got.err, got.npc,
               want.req, want.addr, want.valid, want.err, want.npc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    vec_t        tbl[$];
    out_t        got, mexp;
    int          err_pulses;
    int          ack_pct;
    logic [31:0] pc_reg;
    in_t         x;

    tbl.push_back({mk(1, 32'h1234, 0, 0, 0, 0, 0, 0), mo(0, 32'h0,   0, 0, RESET_VEC)});
    tbl.push_back({mk(0, 32'h0,    0, 0, 0, 0, 0, 0), mo(0, 32'h0,   0, 0, RESET_VEC)});
    tbl.push_back({mk(0, 32'h0,    0, 0, 0, 0, 0, 1), mo(1, 32'h0,   1, 0, 32'h4)});
    tbl.push_back({mk(0, 32'h4,    0, 0, 0, 0, 0, 1), mo(1, 32'h4,   1, 0, 32'h8)});
    tbl.push_back({mk(0, 32'h8,    0, 0, 0, 0, 0, 1), mo(1, 32'h8,   1, 0, 32'hC)});
    tbl.push_back({mk(0, 32'hC,    0, 0, 0, 0, 0, 1), mo(1, 32'hC,   1, 0, 32'h10)});
    tbl.push_back({mk(0, 32'h10,   0, 1, 32'h200, 1, 32'h300, 1), mo(1, 32'h10, 1, 0, 32'h200)});
    tbl.push_back({mk(0, 32'h200,  0, 0, 0, 1, 32'h40, 0), mo(1, 32'h200, 0, 0, 32'h200)});
    tbl.push_back({mk(0, 32'h200,  0, 0, 0, 0, 0, 0), mo(1, 32'h200, 0, 0, 32'h200)});
    tbl.push_back({mk(0, 32'h200,  0, 0, 0, 0, 0, 1), mo(1, 32'h200, 1, 0, 32'h40)});
    tbl.push_back({mk(0, 32'h40,   0, 0, 0, 0, 0, 1), mo(1, 32'h40,  1, 0, 32'h44)});
    tbl.push_back({mk(0, 32'h8,    1, 0, 0, 0, 0, 1), mo(1, 32'h8,   1, 0, 32'hC)});
    tbl.push_back({mk(0, 32'hC,    1, 0, 0, 0, 0, 1), mo(0, 32'h0,   0, 0, 32'hC)});
    tbl.push_back({mk(0, 32'hC,    1, 0, 0, 0, 0, 0), mo(0, 32'h0,   0, 0, 32'hC)});
    tbl.push_back({mk(0, 32'hC,    0, 0, 0, 0, 0, 0), mo(0, 32'h0,   0, 0, 32'hC)});
    tbl.push_back({mk(0, 32'hC,    0, 0, 0, 0, 0, 1), mo(1, 32'hC,   1, 0, 32'h10)});
    tbl.push_back({mk(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1), mo(1, 32'hFFFF_FFFC, 1, 0, 32'h0)});

    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      cycle(tbl[i].stim, got, mexp);
      check($sformatf("table[%0d]", i), got, tbl[i].want);
    end

    // Fetch timeout: 16 unacknowledged cycles, one-cycle trap, resume at TRAP_VEC.
    err_pulses = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(mk(0, 32'h10, 0, 0, 0, 0, 0, 0), got, mexp);
      err_pulses += int'(got.err);
      check($sformatf("timeout_wait[%0d]", k), got, mo(1, 32'h10, 0, 0, 32'h10));
    end
    cycle(mk(0, 32'h10, 0, 0, 0, 0, 0, 0), got, mexp);
    err_pulses += int'(got.err);
    check("timeout_trap", got, mo(0, 32'h0, 0, 1, TRAP_VEC));
    cycle(mk(0, TRAP_VEC, 0, 0, 0, 0, 0, 0), got, mexp);
    err_pulses += int'(got.err);
    check("timeout_resume", got, mo(1, TRAP_VEC, 0, 0, TRAP_VEC));
    check_int("timeout_err_pulses", err_pulses, 1);

    // Reset mid-FETCH with a pending jump: the jump target is never used.
    cycle(mk(0, 32'h80, 0, 1, 32'h500, 0, 0, 0), got, mexp);
    check("rst_pend_latch", got, mo(1, 32'h80, 0, 0, 32'h80));
    cycle(mk(1, 32'h80, 0, 0, 0, 0, 0, 1), got, mexp);
    check("rst_mid_fetch", got, mo(0, 32'h0, 0, 0, RESET_VEC));
    cycle(mk(0, RESET_VEC, 0, 0, 0, 0, 0, 1), got, mexp);
    check("rst_idle", got, mo(0, 32'h0, 0, 0, RESET_VEC));
    cycle(mk(0, RESET_VEC, 0, 0, 0, 0, 0, 1), got, mexp);
    check("rst_first_fetch", got, mo(1, RESET_VEC, 1, 0, RESET_VEC + 32'd4));

    // Ack coinciding with the timeout condition advances instead of trapping.
    err_pulses = 0;
    for (int k = 0; k < 15; k++) begin
      cycle(mk(0, 32'h20, 0, 0, 0, 0, 0, 0), got, mexp);
      err_pulses += int'(got.err);
    end
    cycle(mk(0, 32'h20, 0, 0, 0, 0, 0, 1), got, mexp);
    check("ack_at_timeout", got, mo(1, 32'h20, 1, 0, 32'h24));
    cycle(mk(0, 32'h24, 0, 0, 0, 0, 0, 0), got, mexp);
    err_pulses += int'(got.err);
    check("ack_at_timeout_next", got, mo(1, 32'h24, 0, 0, 32'h24));
    check_int("ack_at_timeout_no_err", err_pulses, 0);

    // Random stimulus with the PC register closed around the DUT.
    pc_reg  = 32'h28;
    ack_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        case ($urandom_range(3))
          0:       ack_pct = 0;
          1:       ack_pct = 12;
          2:       ack_pct = 50;
          default: ack_pct = 90;
        endcase
      end
      x.rst   = ($urandom_range(99) == 0);
      x.stall = ($urandom_range(3) == 0);
      x.jump  = ($urandom_range(15) == 0);
      x.br    = ($urandom_range(7) == 0);
      x.jt    = $urandom & 32'hFFFF_FFFC;
      x.bt    = $urandom & 32'hFFFF_FFFC;
      x.ack   = (int'($urandom_range(99)) < ack_pct);
      x.pc    = ($urandom_range(31) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc_reg;
      cycle(x, got, mexp);
      check($sformatf("random[%0d]", n), got, mexp);
      pc_reg = got.npc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be: RESET_VEC, default 32'h0000_0000, fetch start address; TRAP_VEC, default 32'h0000_0080, fetch-error target; TIMEOUT, default 15, maximum FETCH cycles without ack.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_pc  input  32  current PC register value.
REQ-005 o_next_pc  output  32  value loaded by the PC register every clock.
REQ-006 i_stall  input  1  pipeline stall; PC SHALL NOT advance while high.
REQ-007 i_jump, i_jump_target  input  1/32  jump redirect strobe and target.
REQ-008 i_br_taken, i_br_target  input  1/32  taken-branch strobe and target.
REQ-009 o_imem_req, o_imem_addr  output  1/32  instruction-fetch request and address.
REQ-010 i_imem_ack  input  1  fetch complete; one-cycle pulse.
REQ-011 o_inst_valid  output  1  fetched instruction accepted this cycle.
REQ-012 o_fetch_err  output  1  one-cycle fetch-timeout pulse.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, HOLD and TRAP.
REQ-014 In IDLE, o_next_pc SHALL be RESET_VEC, o_imem_req SHALL be 0, and the next state SHALL be FETCH.
REQ-015 In FETCH, o_imem_req SHALL be 1 and o_imem_addr SHALL equal i_pc.
REQ-016 FETCH with i_imem_ack=1 is the advance cycle: o_inst_valid=1, o_next_pc=selected target (REQ-018), next state HOLD if i_stall=1, else FETCH.
REQ-017 In every non-advance cycle outside IDLE and TRAP, o_next_pc SHALL equal i_pc (hold).
REQ-018 Advance target priority SHALL be: same-cycle i_jump; then same-cycle i_br_taken; then pending redirect; then i_pc+4 (mod 2^32, wrap to 0).
REQ-019 A redirect strobe in a non-advance cycle SHALL be latched as pending (jump over branch; a newer strobe overwrites an older pending one).
REQ-020 Pending SHALL clear on the advance cycle that consumes it and on entry to TRAP.
REQ-021 In HOLD, o_imem_req SHALL be 0; i_stall=0 SHALL move to FETCH; i_imem_ack SHALL be ignored.
REQ-022 i_imem_ack outside FETCH SHALL be ignored, with o_inst_valid=0.
REQ-023 A 4-bit wait counter SHALL clear on FETCH entry and on ack, and increment each FETCH cycle without ack.
REQ-024 When the wait counter equals TIMEOUT and no ack is present, the next state SHALL be TRAP.
REQ-025 TRAP SHALL last exactly one cycle: o_fetch_err=1, o_imem_req=0, o_next_pc=TRAP_VEC; next state FETCH.
REQ-026 An ack in the same cycle as the timeout condition SHALL win: normal advance, no TRAP.
REQ-027 i_stall SHALL NOT block an ack in FETCH; it is honoured by entering HOLD after the advance.

Reset
REQ-028 i_rst=1 at a clock edge SHALL force state IDLE, clear pending and the wait counter, from any state including mid-FETCH.
REQ-029 While i_rst=1: o_imem_req=0, o_inst_valid=0, o_fetch_err=0, o_imem_addr=0, o_next_pc=RESET_VEC.

Verification
REQ-030 Reset release, ack on every FETCH cycle, no stall -> o_imem_addr sequence 0,4,8,12; o_inst_valid high every cycle from the 2nd cycle on.
REQ-031 i_pc=0x10, i_jump=1 with target 0x200 and i_br_taken=1 with target 0x300 in the ack cycle -> o_next_pc=0x200.
REQ-032 i_br_taken=1 with target 0x40 two cycles before the ack, nothing else -> o_next_pc=0x40 at the ack; the following ack gives 0x44.
REQ-033 No ack for 16 FETCH cycles -> o_fetch_err pulses once, o_next_pc=0x80, then FETCH resumes with o_imem_addr=0x80.
REQ-034 i_stall=1 during the ack at i_pc=0x8 -> o_next_pc=0xC, then HOLD with o_next_pc=0xC and o_imem_req=0 until i_stall falls.
REQ-035 i_rst=1 mid-FETCH with a pending redirect -> IDLE; after release, the first fetch is at RESET_VEC and the pending target is never used.
